// File: rtl/t_sram_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : t_sram_scheduler
// Brief    : Owns the single-port T-spill SRAM; schedules host bulk load,
//            T-refill reads and (t,v,f) write-backs for the SW datapath.
// Revision : 1.0 - initial release
// ============================================================================
module t_sram_scheduler #(
    parameter int  GROUP_W    = 18,
    parameter int  T_PER_WORD = 7,
    parameter int  ADDR_W     = 8,
    parameter int  T_SIZE_W   = 11,
    localparam int DATA_W     = GROUP_W * T_PER_WORD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [T_SIZE_W-1:0] i_T_size,
    input  logic                i_start,
    input  logic                i_done,
    output logic                o_busy,
    input  logic                i_load_valid,
    input  logic [DATA_W-1:0]   i_load_data,
    output logic                o_load_ready,
    input  logic                i_dp_request,
    output logic [DATA_W+3:0]   o_dp_data,
    input  logic                i_dp_send,
    input  logic [DATA_W-1:0]   i_dp_data,
    output logic                o_sram_cen,
    output logic                o_sram_wen,
    output logic [ADDR_W-1:0]   o_sram_addr,
    output logic [DATA_W-1:0]   o_sram_d,
    input  logic [DATA_W-1:0]   i_sram_q,
    output logic                o_err
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_LOAD     = 2'd1;
    localparam logic [1:0] c_RUN      = 2'd2;
    localparam logic [2:0] c_CNT_FULL = 3'b111;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ADDR_W:0]     r_words;
    logic [2:0]          r_last_cnt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_lead;
    logic                r_wb_full;
    logic [DATA_W-1:0]   r_wb_data;
    logic                r_rd_inflight;
    logic                r_rd_last;
    logic [2:0]          r_hold_cnt;
    logic [DATA_W-1:0]   r_hold_payload;
    logic                r_err;

    logic [T_SIZE_W-1:0] w_tsz;
    logic [T_SIZE_W-1:0] w_tsz_mod;
    logic [T_SIZE_W:0]   w_words_calc;
    logic [2:0]          w_last_cnt;
    logic [ADDR_W-1:0]   w_last_addr;
    logic                w_wr_at_last;
    logic                w_rd_at_last;
    logic                w_wb_pending;
    logic [DATA_W-1:0]   w_wb_data;
    logic [2:0]          w_resp_cnt;
    logic                w_rd_issue;
    logic                w_wr_issue;
    logic                w_sram_cen;
    logic                w_sram_wen;
    logic [ADDR_W-1:0]   w_sram_addr;
    logic [DATA_W-1:0]   w_sram_d;

    // An empty T is handled as a single group so there is always one word.
    assign w_tsz        = (i_T_size == '0) ? T_SIZE_W'(1) : i_T_size;
    assign w_words_calc = ({1'b0, w_tsz} + (T_SIZE_W+1)'(T_PER_WORD - 1))
                          / (T_SIZE_W+1)'(T_PER_WORD);
    assign w_tsz_mod    = w_tsz % T_SIZE_W'(T_PER_WORD);
    assign w_last_cnt   = (w_tsz_mod == '0) ? 3'(T_PER_WORD) : 3'(w_tsz_mod);

    assign w_last_addr  = ADDR_W'(r_words - (ADDR_W+1)'(1));
    assign w_wr_at_last = (r_wr_ptr == w_last_addr);
    assign w_rd_at_last = (r_rd_ptr == w_last_addr);

    // A send with an empty buffer is written through in the same cycle.
    assign w_wb_pending = r_wb_full | i_dp_send;
    assign w_wb_data    = r_wb_full ? r_wb_data : i_dp_data;
    assign w_resp_cnt   = r_rd_last ? r_last_cnt : c_CNT_FULL;

    always_comb begin
        w_state_nxt = r_state;
        w_sram_cen  = 1'b0;
        w_sram_wen  = 1'b0;
        w_sram_addr = '0;
        w_sram_d    = '0;
        w_rd_issue  = 1'b0;
        w_wr_issue  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (i_start) w_state_nxt = c_LOAD;
            end
            c_LOAD: begin
                if (i_load_valid) begin
                    w_sram_cen  = 1'b1;
                    w_sram_wen  = 1'b1;
                    w_sram_addr = r_wr_ptr;
                    w_sram_d    = i_load_data;
                    if (w_wr_at_last) w_state_nxt = c_RUN;
                end
                if (i_done) w_state_nxt = c_IDLE;
            end
            c_RUN: begin
                if (w_wb_pending) begin
                    w_wr_issue  = 1'b1;
                    w_sram_cen  = 1'b1;
                    w_sram_wen  = 1'b1;
                    w_sram_addr = r_wr_ptr;
                    w_sram_d    = w_wb_data;
                end else if (i_dp_request && !r_rd_inflight && (r_lead < r_words)) begin
                    w_rd_issue  = 1'b1;
                    w_sram_cen  = 1'b1;
                    w_sram_addr = r_rd_ptr;
                end
                if (i_done) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_words        <= '0;
            r_last_cnt     <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_lead         <= '0;
            r_wb_full      <= 1'b0;
            r_wb_data      <= '0;
            r_rd_inflight  <= 1'b0;
            r_rd_last      <= 1'b0;
            r_hold_cnt     <= '0;
            r_hold_payload <= '0;
            r_err          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rd_inflight <= w_rd_issue;
            r_rd_last     <= w_rd_issue & w_rd_at_last;
            if (r_rd_inflight) begin
                r_hold_cnt     <= w_resp_cnt;
                r_hold_payload <= i_sram_q;
            end
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_words    <= (ADDR_W+1)'(w_words_calc);
                        r_last_cnt <= w_last_cnt;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_lead     <= '0;
                        r_wb_full  <= 1'b0;
                    end
                end
                c_LOAD: begin
                    if (i_load_valid) begin
                        if (w_wr_at_last) begin
                            r_wr_ptr <= '0;
                            r_rd_ptr <= '0;
                            r_lead   <= '0;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                        end
                    end
                end
                c_RUN: begin
                    if (w_wr_issue) begin
                        r_wr_ptr <= w_wr_at_last ? '0 : r_wr_ptr + ADDR_W'(1);
                        if (r_lead != '0) r_lead <= r_lead - (ADDR_W+1)'(1);
                    end else if (w_rd_issue) begin
                        r_rd_ptr <= w_rd_at_last ? '0 : r_rd_ptr + ADDR_W'(1);
                        r_lead   <= r_lead + (ADDR_W+1)'(1);
                    end
                    // Buffer bookkeeping: a drain frees the entry for a concurrent send.
                    if (w_wr_issue) begin
                        r_wb_full <= i_dp_send & r_wb_full;
                        if (i_dp_send & r_wb_full) r_wb_data <= i_dp_data;
                    end else if (i_dp_send) begin
                        if (r_wb_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_wb_full <= 1'b1;
                            r_wb_data <= i_dp_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = (r_state != c_IDLE);
    assign o_load_ready = (r_state == c_LOAD);
    assign o_dp_data    = r_rd_inflight ? {1'b1, w_resp_cnt, i_sram_q}
                                        : {1'b0, r_hold_cnt, r_hold_payload};
    assign o_sram_cen   = w_sram_cen;
    assign o_sram_wen   = w_sram_wen;
    assign o_sram_addr  = w_sram_addr;
    assign o_sram_d     = w_sram_d;
    assign o_err        = r_err;

endmodule
`default_nettype wire
